// File: rtl/circle_buf_mc.sv
// circle_buf_mc: single-clock, multi-channel, triggered ping-pong capture buffer.
// The write side fills one bank around a trigger (pre-trigger depth programmable),
// while the read side streams the other bank one channel word per strobe.
// Optional build macro: CIRCLE_BUF_MC_OVF_EN adds the ovf_cnt output (dropped-sample count).
module circle_buf_mc #(
    parameter int aw  = 6,
    parameter int dw  = 16,
    parameter int nch = 4,
    parameter int cw  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [nch*dw-1:0] data_w,
    input  logic              stb_w,
    input  logic              trig_ext,
    input  logic              trig_internal_ena,
    input  logic [aw-1:0]     trigger_location,
    input  logic              stb_r,
    input  logic              rewind,
    output logic [dw-1:0]     data_r,
    output logic              data_gate_out,
    output logic [cw-1:0]     chan_r,
    output logic              empty_flag,
    output logic              full_flag,
    output logic [31:0]       trig_stamp
`ifdef CIRCLE_BUF_MC_OVF_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    localparam int            DEPTH     = 1 << aw;
    localparam logic [aw:0]   FULL_CNT  = (aw+1)'(DEPTH);
    localparam logic [aw:0]   CNT_ONE   = (aw+1)'(1);
    localparam logic [aw-1:0] ADDR_ONE  = aw'(1);
    localparam logic [aw-1:0] LAST_SAMP = aw'(DEPTH - 1);
    localparam logic [cw-1:0] LAST_CH   = cw'(nch - 1);
    localparam logic [cw-1:0] CH_ONE    = cw'(1);

    typedef enum logic [1:0] {PRE, ARMED, POST, DONE} wstate_t;

    // Sample storage: two banks of 2^aw samples, each sample holds all channels.
    logic [nch*dw-1:0] mem [2][DEPTH];

    wstate_t       st_q, st_d;
    logic          entry_q, entry_d;
    logic [aw-1:0] tl_q, tl_d, tl_eff;
    logic [aw-1:0] w_addr_q, w_addr_d;
    logic [aw:0]   cnt_q, cnt_d;
    logic          w_bank_q, w_bank_d;
    logic [aw-1:0] addr_start_q [2];
    logic [aw-1:0] addr_start_d [2];
    logic [31:0]   stamp_q [2];
    logic [31:0]   stamp_d [2];
    logic [31:0]   ts_q, ts_d;
    logic          mem_we, swap, trig;

    logic          empty_q, empty_d;
    logic          loaded_q, loaded_d;
    logic [aw-1:0] r_samp_q, r_samp_d;
    logic [cw-1:0] r_chan_q, r_chan_d;
    logic [dw-1:0] data_r_q, data_r_d;
    logic [cw-1:0] chan_r_q, chan_r_d;
    logic          gate_q, gate_d;
    logic [31:0]   trig_stamp_q, trig_stamp_d;

    logic          r_bank;
    logic [aw-1:0] rd_addr;
    logic [nch*dw-1:0] rd_sample;
    logic [dw-1:0] rd_word;

    // Read-side word selection from the bank not being written.
    always_comb begin
        r_bank    = ~w_bank_q;
        rd_addr   = addr_start_q[r_bank] + r_samp_q;
        rd_sample = mem[r_bank][rd_addr];
        rd_word   = rd_sample[r_chan_q*dw +: dw];
    end

    // Write FSM: pre-trigger fill, armed circular capture, post-trigger fill, hold until swap.
    always_comb begin
        st_d         = st_q;
        entry_d      = 1'b0;
        tl_d         = tl_q;
        w_addr_d     = w_addr_q;
        cnt_d        = cnt_q;
        w_bank_d     = w_bank_q;
        addr_start_d = addr_start_q;
        stamp_d      = stamp_q;
        ts_d         = ts_q + 32'd1;
        mem_we       = 1'b0;
        swap         = 1'b0;
        trig         = stb_w & (trig_ext | trig_internal_ena);
        // The pre-trigger depth is taken from the port only on the first PRE cycle.
        tl_eff       = entry_q ? trigger_location : tl_q;
        if (entry_q) tl_d = trigger_location;
        case (st_q)
            PRE: begin
                if (tl_eff == '0) begin
                    st_d = ARMED;
                end else if (stb_w) begin
                    mem_we   = 1'b1;
                    w_addr_d = w_addr_q + ADDR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_d == {1'b0, tl_eff}) st_d = ARMED;
                end
            end
            ARMED: begin
                if (stb_w) begin
                    mem_we   = 1'b1;
                    w_addr_d = w_addr_q + ADDR_ONE;
                    if (trig) begin
                        addr_start_d[w_bank_q] = w_addr_q - tl_q;
                        stamp_d[w_bank_q]      = ts_q;
                        cnt_d = {1'b0, tl_q} + CNT_ONE;
                        st_d  = (cnt_d == FULL_CNT) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (stb_w) begin
                    mem_we   = 1'b1;
                    w_addr_d = w_addr_q + ADDR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_d == FULL_CNT) st_d = DONE;
                end
            end
            DONE: begin
                // Hand the finished bank to the reader as soon as it has nothing left.
                if (empty_q) begin
                    swap     = 1'b1;
                    w_bank_d = ~w_bank_q;
                    st_d     = PRE;
                    entry_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: st_d = PRE;
        endcase
    end

    // Read pointer, output word register and frame availability.
    always_comb begin
        r_samp_d     = r_samp_q;
        r_chan_d     = r_chan_q;
        empty_d      = empty_q;
        loaded_d     = loaded_q;
        data_r_d     = data_r_q;
        chan_r_d     = chan_r_q;
        gate_d       = 1'b0;
        trig_stamp_d = trig_stamp_q;
        if (swap) begin
            empty_d      = 1'b0;
            loaded_d     = 1'b1;
            r_samp_d     = '0;
            r_chan_d     = '0;
            trig_stamp_d = stamp_q[w_bank_q];
        end
        if (rewind) begin
            if (loaded_q) begin
                r_samp_d = '0;
                r_chan_d = '0;
                empty_d  = 1'b0;
            end
        end else if (stb_r && !empty_q) begin
            data_r_d = rd_word;
            chan_r_d = r_chan_q;
            gate_d   = 1'b1;
            if (r_chan_q == LAST_CH) begin
                r_chan_d = '0;
                r_samp_d = r_samp_q + ADDR_ONE;
                if (r_samp_q == LAST_SAMP) empty_d = 1'b1;
            end else begin
                r_chan_d = r_chan_q + CH_ONE;
            end
        end
    end

    // Sample memory write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[w_bank_q][w_addr_q] <= data_w;
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q         <= PRE;
            entry_q      <= 1'b1;
            tl_q         <= '0;
            w_addr_q     <= '0;
            cnt_q        <= '0;
            w_bank_q     <= 1'b0;
            addr_start_q <= '{default: '0};
            stamp_q      <= '{default: '0};
            ts_q         <= '0;
            empty_q      <= 1'b1;
            loaded_q     <= 1'b0;
            r_samp_q     <= '0;
            r_chan_q     <= '0;
            data_r_q     <= '0;
            chan_r_q     <= '0;
            gate_q       <= 1'b0;
            trig_stamp_q <= '0;
        end else begin
            st_q         <= st_d;
            entry_q      <= entry_d;
            tl_q         <= tl_d;
            w_addr_q     <= w_addr_d;
            cnt_q        <= cnt_d;
            w_bank_q     <= w_bank_d;
            addr_start_q <= addr_start_d;
            stamp_q      <= stamp_d;
            ts_q         <= ts_d;
            empty_q      <= empty_d;
            loaded_q     <= loaded_d;
            r_samp_q     <= r_samp_d;
            r_chan_q     <= r_chan_d;
            data_r_q     <= data_r_d;
            chan_r_q     <= chan_r_d;
            gate_q       <= gate_d;
            trig_stamp_q <= trig_stamp_d;
        end
    end

    assign data_r        = data_r_q;
    assign chan_r        = chan_r_q;
    assign data_gate_out = gate_q;
    assign empty_flag    = empty_q;
    assign full_flag     = (st_q == DONE);
    assign trig_stamp    = trig_stamp_q;

`ifdef CIRCLE_BUF_MC_OVF_EN
    logic [15:0] ovf_q, ovf_d, ovf_out_q, ovf_out_d, ovf_next;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count samples dropped while the write bank is full; publish the count with the frame.
    always_comb begin
        ovf_next  = (st_q == DONE && stb_w) ? sat_inc16(ovf_q) : ovf_q;
        ovf_d     = swap ? 16'd0 : ovf_next;
        ovf_out_d = swap ? ovf_next : ovf_out_q;
    end

    // Overflow counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q     <= '0;
            ovf_out_q <= '0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign ovf_cnt = ovf_out_q;
`endif

endmodule

// File: tb/tb_circle_buf_mc.sv
// Testbench for circle_buf_mc (aw=4, nch=2, dw=16): table-driven readout vectors
// plus directed sequences for triggering, overflow, rewind and reset corner cases.
module tb_circle_buf_mc;

    logic        clk;
    logic        reset_n;
    logic [31:0] data_w;
    logic        stb_w;
    logic        trig_ext;
    logic        trig_internal_ena;
    logic [3:0]  trigger_location;
    logic        stb_r;
    logic        rewind;
    logic [15:0] data_r;
    logic        data_gate_out;
    logic [3:0]  chan_r;
    logic        empty_flag;
    logic        full_flag;
    logic [31:0] trig_stamp;
`ifdef CIRCLE_BUF_MC_OVF_EN
    logic [15:0] ovf_cnt;
`endif

    circle_buf_mc #(.aw(4), .dw(16), .nch(2), .cw(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .data_w            (data_w),
        .stb_w             (stb_w),
        .trig_ext          (trig_ext),
        .trig_internal_ena (trig_internal_ena),
        .trigger_location  (trigger_location),
        .stb_r             (stb_r),
        .rewind            (rewind),
        .data_r            (data_r),
        .data_gate_out     (data_gate_out),
        .chan_r            (chan_r),
        .empty_flag        (empty_flag),
        .full_flag         (full_flag),
        .trig_stamp        (trig_stamp)
`ifdef CIRCLE_BUF_MC_OVF_EN
        ,
        .ovf_cnt           (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: counts clock edges since reset release.
    logic [31:0] ts_m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_m <= 32'd0;
        else          ts_m <= ts_m + 32'd1;
    end

    typedef struct {
        logic        stb_r;
        logic        rewind;
        logic        exp_gate;
        logic [15:0] exp_data;
        logic [3:0]  exp_chan;
        logic        exp_empty;
    } vec_t;

    vec_t tbl [46];
    int   nvec = 0;
    int   nerr = 0;
    logic [31:0] exp_ts;

    function automatic logic [15:0] wexp(input int base, input int k);
        return 16'(((k % 2) * 256) + base + (k / 2));
    endfunction

    function automatic vec_t mk(input logic s, input logic rw, input logic g,
                                input logic [15:0] d, input logic [3:0] c, input logic e);
        vec_t v;
        v.stb_r = s; v.rewind = rw; v.exp_gate = g;
        v.exp_data = d; v.exp_chan = c; v.exp_empty = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int n, input logic trig);
        data_w   = {16'(n + 256), 16'(n)};
        stb_w    = 1'b1;
        trig_ext = trig;
        tick();
        stb_w    = 1'b0;
        trig_ext = 1'b0;
    endtask

    task automatic read_words(input int base, input int first, input int last, input string tag);
        for (int k = first; k <= last; k++) begin
            stb_r = 1'b1;
            tick();
            chk({tag, "_gate"}, 32'(data_gate_out), 32'd1);
            chk({tag, "_data"}, 32'(data_r), 32'(wexp(base, k)));
            chk({tag, "_chan"}, 32'(chan_r), 32'(k % 2));
        end
        stb_r = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, 32'(empty_flag), 32'd1);
        chk({tag, "_full"},  32'(full_flag), 32'd0);
        chk({tag, "_gate"},  32'(data_gate_out), 32'd0);
        chk({tag, "_data"},  32'(data_r), 32'd0);
        chk({tag, "_chan"},  32'(chan_r), 32'd0);
        chk({tag, "_stamp"}, trig_stamp, 32'd0);
    endtask

    initial begin
        // Readout vectors for the first frame (ch0=n, ch1=n+0x100), then empty, rewind cases.
        for (int i = 0; i < 32; i++)
            tbl[i] = mk(1'b1, 1'b0, 1'b1, wexp(0, i), 4'(i % 2), (i == 31));
        tbl[32] = mk(1'b1, 1'b0, 1'b0, 16'h010F, 4'd1, 1'b1);
        tbl[33] = mk(1'b0, 1'b1, 1'b0, 16'h010F, 4'd1, 1'b0);
        for (int k = 0; k < 10; k++)
            tbl[34 + k] = mk(1'b1, 1'b0, 1'b1, wexp(0, k), 4'(k % 2), 1'b0);
        tbl[44] = mk(1'b1, 1'b1, 1'b0, 16'h0104, 4'd1, 1'b0);
        tbl[45] = mk(1'b1, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0);

        reset_n = 1'b0; data_w = '0; stb_w = 1'b0; trig_ext = 1'b0;
        trig_internal_ena = 1'b1; trigger_location = 4'd0; stb_r = 1'b0; rewind = 1'b0;
        exp_ts = '0;
        repeat (3) tick();
        chk_reset_state("rst0");

        // Frame 1: no pre-trigger, internal trigger on the first armed sample.
        reset_n = 1'b1;
        tick(); tick();
        for (int n = 0; n < 16; n++) begin
            if (n == 0) exp_ts = ts_m;
            wr(n, 1'b0);
        end
        chk("f1_full_done", 32'(full_flag), 32'd1);
        chk("f1_empty_pre_swap", 32'(empty_flag), 32'd1);
        tick();
        chk("f1_full_swapped", 32'(full_flag), 32'd0);
        chk("f1_empty_swapped", 32'(empty_flag), 32'd0);
        chk("f1_stamp", trig_stamp, exp_ts);

        for (int i = 0; i < 46; i++) begin
            stb_r  = tbl[i].stb_r;
            rewind = tbl[i].rewind;
            tick();
            chk($sformatf("vec%0d_gate", i),  32'(data_gate_out), 32'(tbl[i].exp_gate));
            chk($sformatf("vec%0d_data", i),  32'(data_r), 32'(tbl[i].exp_data));
            chk($sformatf("vec%0d_chan", i),  32'(chan_r), 32'(tbl[i].exp_chan));
            chk($sformatf("vec%0d_empty", i), 32'(empty_flag), 32'(tbl[i].exp_empty));
        end
        stb_r = 1'b0; rewind = 1'b0;

        // Frame 2: 5 pre-trigger samples, external trigger on sample 20; early and
        // strobe-less triggers must be ignored.
        reset_n = 1'b0;
        trig_internal_ena = 1'b0; trigger_location = 4'd5;
        tick(); tick();
        reset_n = 1'b1;
        for (int n = 0; n < 31; n++) begin
            if (n == 11) begin
                stb_w = 1'b0; trig_ext = 1'b1;
                tick();
                trig_ext = 1'b0;
            end
            if (n == 20) exp_ts = ts_m;
            wr(n, (n < 3) || (n == 20));
        end
        chk("f2_full_done", 32'(full_flag), 32'd1);
        trig_internal_ena = 1'b1; trigger_location = 4'd0;
        tick();
        chk("f2_empty_swapped", 32'(empty_flag), 32'd0);
        chk("f2_full_swapped", 32'(full_flag), 32'd0);
        chk("f2_stamp", trig_stamp, exp_ts);
        read_words(15, 0, 19, "f2a");

        // Frame 3 completes while frame 2 is mid-read; 7 extra samples are dropped.
        exp_ts = ts_m;
        for (int n = 'h40; n < 'h50; n++) wr(n, 1'b0);
        chk("f3_full_done", 32'(full_flag), 32'd1);
        chk("f3_empty_midread", 32'(empty_flag), 32'd0);
        for (int n = 'h50; n < 'h57; n++) wr(n, 1'b0);
        chk("f3_full_dropping", 32'(full_flag), 32'd1);
        read_words(15, 20, 31, "f2b");
        chk("f2_empty_after_last", 32'(empty_flag), 32'd1);
        chk("f2_full_after_last", 32'(full_flag), 32'd1);
        tick();
        chk("f3_empty_swapped", 32'(empty_flag), 32'd0);
        chk("f3_full_swapped", 32'(full_flag), 32'd0);
        chk("f3_stamp", trig_stamp, exp_ts);
`ifdef CIRCLE_BUF_MC_OVF_EN
        chk("f3_ovf_cnt", 32'(ovf_cnt), 32'd7);
`endif
        read_words('h40, 0, 31, "f3");
        chk("f3_empty_end", 32'(empty_flag), 32'd1);

        // Reset asserted between clock edges while the write side is in POST.
        for (int n = 'h70; n < 'h78; n++) wr(n, 1'b0);
        chk("post_full", 32'(full_flag), 32'd0);
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        chk("rw_empty", 32'(empty_flag), 32'd0);
        read_words('h40, 0, 1, "f3r");
        #2 reset_n = 1'b0;
        #1 chk_reset_state("rst_async");
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        exp_ts = ts_m;
        for (int n = 'h60; n < 'h70; n++) wr(n, 1'b0);
        chk("f4_full_done", 32'(full_flag), 32'd1);
        tick();
        chk("f4_empty_swapped", 32'(empty_flag), 32'd0);
        chk("f4_stamp", trig_stamp, exp_ts);
        read_words('h60, 0, 31, "f4");
        chk("f4_empty_end", 32'(empty_flag), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
